simon_input_encoder: RTL and testbench

SIMON_INPUT_ENCODER -- requirements
Module: simon_input_encoder

---
 rtl/simon_input_encoder_pkg.sv | 55 +++++
 rtl/simon_input_encoder_debounce.sv | 47 ++++
 rtl/simon_input_encoder.sv | 153 +++++++++++++++
 tb/tb_simon_input_encoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_input_encoder_pkg.sv
// Shared Simon definitions: color codes, encoder state encodings and
// small helpers that map between button vectors and color codes.
package simon_input_encoder_pkg;

  typedef logic [2:0] color_t;

  localparam color_t COLOR_NONE   = 3'd0;
  localparam color_t COLOR_RED    = 3'd1;
  localparam color_t COLOR_BLUE   = 3'd2;
  localparam color_t COLOR_YELLOW = 3'd3;
  localparam color_t COLOR_GREEN  = 3'd4;

  // Button vector bit positions: [0]=U, [1]=R, [2]=D, [3]=L
  localparam int BTN_IDX_U = 0;
  localparam int BTN_IDX_R = 1;
  localparam int BTN_IDX_D = 2;
  localparam int BTN_IDX_L = 3;

  // One-hot encoder states; bit order matches the q_* flag outputs
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_HELD  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_VALID = 4'b1000
  } enc_state_e;

  // Number of buttons currently pressed (0..4)
  function automatic logic [2:0] count_pressed(input logic [3:0] btn);
    count_pressed = {2'b00, btn[0]} + {2'b00, btn[1]} +
                    {2'b00, btn[2]} + {2'b00, btn[3]};
  endfunction

  // Single pressed button to its color; anything else maps to NONE
  function automatic color_t btn_to_color(input logic [3:0] btn);
    case (btn)
      4'b0001: btn_to_color = COLOR_RED;
      4'b0010: btn_to_color = COLOR_BLUE;
      4'b0100: btn_to_color = COLOR_YELLOW;
      4'b1000: btn_to_color = COLOR_GREEN;
      default: btn_to_color = COLOR_NONE;
    endcase
  endfunction

  // Color back to the button mask that produced it
  function automatic logic [3:0] color_to_btn(input color_t color);
    case (color)
      COLOR_RED:    color_to_btn = 4'b0001;
      COLOR_BLUE:   color_to_btn = 4'b0010;
      COLOR_YELLOW: color_to_btn = 4'b0100;
      COLOR_GREEN:  color_to_btn = 4'b1000;
      default:      color_to_btn = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/simon_input_encoder_debounce.sv
// One button: two-flop synchronizer followed by a saturating debounce
// counter. The debounced level flips only after the synchronized level
// has disagreed with it for DB_CYCLES consecutive cycles.
module simon_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Synchronize the raw input and count consecutive disagreeing cycles
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r >= CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign btn_level = level_r;

endmodule

// File: rtl/simon_input_encoder.sv
// Simon input encoder: debounces the four color buttons and turns one
// clean press-and-release into a color code held until acknowledged.
// Overlapping presses are discarded with a one-cycle multi_err pulse.
module simon_input_encoder
  import simon_input_encoder_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ON,
  input  logic       Btn_U,
  input  logic       Btn_R,
  input  logic       Btn_D,
  input  logic       Btn_L,
  input  logic       code_ack,
  output logic [2:0] color_code,
  output logic       code_valid,
  output logic       multi_err,
  output logic       q_Idle,
  output logic       q_Held,
  output logic       q_Drain,
  output logic       q_Valid
);

  logic [3:0] btn_raw_s;
  logic [3:0] btn_level_s;
  logic [2:0] pressed_cnt_s;
  logic       any_pressed_s;
  logic       other_pressed_s;

  enc_state_e state_r;
  enc_state_e state_next_s;
  color_t     code_r;
  color_t     code_next_s;
  color_t     color_code_r;
  color_t     color_next_s;
  logic       code_valid_r;
  logic       valid_next_s;
  logic       multi_err_r;
  logic       err_next_s;

  assign btn_raw_s = {Btn_L, Btn_D, Btn_R, Btn_U};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      simon_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .Clk       (Clk),
        .Reset     (Reset),
        .btn_raw   (btn_raw_s[gi]),
        .btn_level (btn_level_s[gi])
      );
    end
  endgenerate

  assign pressed_cnt_s   = count_pressed(btn_level_s);
  assign any_pressed_s   = |btn_level_s;
  // A press of anything other than the latched button
  assign other_pressed_s = |(btn_level_s & ~color_to_btn(code_r));

  // Next state and next registered outputs; ON=0 overrides everything
  always_comb begin
    state_next_s = state_r;
    code_next_s  = code_r;
    color_next_s = color_code_r;
    valid_next_s = code_valid_r;
    err_next_s   = 1'b0;
    if (!ON) begin
      state_next_s = ST_IDLE;
      code_next_s  = COLOR_NONE;
      color_next_s = COLOR_NONE;
      valid_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pressed_cnt_s == 3'd1) begin
            state_next_s = ST_HELD;
            code_next_s  = btn_to_color(btn_level_s);
          end else if (pressed_cnt_s >= 3'd2) begin
            state_next_s = ST_DRAIN;
            err_next_s   = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (other_pressed_s) begin
            state_next_s = ST_DRAIN;
            code_next_s  = COLOR_NONE;
            err_next_s   = 1'b1;
          end else if (!any_pressed_s) begin
            state_next_s = ST_VALID;
            color_next_s = code_r;
            valid_next_s = 1'b1;
          end else begin
            state_next_s = ST_HELD;
          end
        end
        ST_VALID: begin
          // Buttons are ignored here; only the ack matters
          if (code_ack) begin
            state_next_s = any_pressed_s ? ST_DRAIN : ST_IDLE;
            code_next_s  = COLOR_NONE;
            color_next_s = COLOR_NONE;
            valid_next_s = 1'b0;
          end else begin
            state_next_s = ST_VALID;
          end
        end
        ST_DRAIN: begin
          if (!any_pressed_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          code_next_s  = COLOR_NONE;
          color_next_s = COLOR_NONE;
          valid_next_s = 1'b0;
        end
      endcase
    end
  end

  // State, latched code and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      code_r       <= COLOR_NONE;
      color_code_r <= COLOR_NONE;
      code_valid_r <= 1'b0;
      multi_err_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      code_r       <= code_next_s;
      color_code_r <= color_next_s;
      code_valid_r <= valid_next_s;
      multi_err_r  <= err_next_s;
    end
  end

  assign color_code = color_code_r;
  assign code_valid = code_valid_r;
  assign multi_err  = multi_err_r;
  assign q_Idle     = state_r[0];
  assign q_Held     = state_r[1];
  assign q_Drain    = state_r[2];
  assign q_Valid    = state_r[3];

endmodule

// File: tb/tb_simon_input_encoder.sv
// Self-checking bench for simon_input_encoder with DB_CYCLES=4.
// Expected output events (code presentations and multi_err pulses) are
// queued as stimulus is applied and matched by a negedge monitor.
module tb_simon_input_encoder;

  localparam int DB = 4;
  localparam int EV_ERR = 8;

  logic       Clk;
  logic       Reset;
  logic       ON;
  logic       Btn_U, Btn_R, Btn_D, Btn_L;
  logic       code_ack;
  logic [2:0] color_code;
  logic       code_valid;
  logic       multi_err;
  logic       q_Idle, q_Held, q_Drain, q_Valid;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  simon_input_encoder #(.DB_CYCLES(DB)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ON         (ON),
    .Btn_U      (Btn_U),
    .Btn_R      (Btn_R),
    .Btn_D      (Btn_D),
    .Btn_L      (Btn_L),
    .code_ack   (code_ack),
    .color_code (color_code),
    .code_valid (code_valid),
    .multi_err  (multi_err),
    .q_Idle     (q_Idle),
    .q_Held     (q_Held),
    .q_Drain    (q_Drain),
    .q_Valid    (q_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input int observed, input int expected);
    checks_cnt++;
    if (observed != expected) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance n rising edges and land 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int valid, input int color, input int state);
    check_value({tag, "_valid"}, int'(code_valid), valid);
    check_value({tag, "_color"}, int'(color_code), color);
    check_value({tag, "_state"}, int'({q_Valid, q_Drain, q_Held, q_Idle}), state);
  endtask

  // Scoreboard monitor: every code presentation / error pulse pops one expectation
  always @(negedge Clk) begin
    if (Reset) begin
      prev_valid = 1'b0;
    end else begin
      if (code_valid && !prev_valid) begin
        if (exp_q.size() == 0) check_value("unexpected_code", int'(color_code), 0);
        else check_value("code_event", int'(color_code), exp_q.pop_front());
      end
      if (multi_err) begin
        if (exp_q.size() == 0) check_value("unexpected_err", EV_ERR, 0);
        else check_value("err_event", EV_ERR, exp_q.pop_front());
      end
      prev_valid = code_valid;
    end
  end

  initial begin
    Reset = 1'b1; ON = 1'b1; code_ack = 1'b0;
    Btn_U = 1'b0; Btn_R = 1'b0; Btn_D = 1'b0; Btn_L = 1'b0;
    tick(2);
    check_outputs("reset", 0, 0, 4'b0001);
    check_value("reset_err", int'(multi_err), 0);
    Reset = 1'b0;
    tick(2);

    // Btn_D held 12 cycles, ack on third valid cycle
    exp_q.push_back(3);
    Btn_D = 1'b1;
    tick(2 + DB);
    check_outputs("d_pre_held", 0, 0, 4'b0001);
    tick(1);
    check_outputs("d_held", 0, 0, 4'b0010);
    tick(12 - (3 + DB));
    Btn_D = 1'b0;
    tick(2 + DB);
    check_outputs("d_pre_valid", 0, 0, 4'b0010);
    tick(1);
    check_outputs("d_valid1", 1, 3, 4'b1000);
    tick(2);
    check_outputs("d_valid3", 1, 3, 4'b1000);
    code_ack = 1'b1;
    tick(1);
    code_ack = 1'b0;
    check_outputs("d_acked", 0, 0, 4'b0001);

    // 3-cycle glitch on Btn_U is filtered out
    Btn_U = 1'b1;
    tick(3);
    Btn_U = 1'b0;
    tick(12);
    check_outputs("glitch", 0, 0, 4'b0001);

    // Btn_L then Btn_R 10 cycles later -> one multi_err, DRAIN, IDLE
    exp_q.push_back(EV_ERR);
    Btn_L = 1'b1;
    tick(10);
    Btn_R = 1'b1;
    tick(2 + DB);
    check_value("lr_no_err_yet", int'(multi_err), 0);
    tick(1);
    check_value("lr_err_pulse", int'(multi_err), 1);
    check_outputs("lr_drain", 0, 0, 4'b0100);
    tick(1);
    check_value("lr_err_one_cycle", int'(multi_err), 0);
    Btn_L = 1'b0; Btn_R = 1'b0;
    tick(2 + DB);
    check_outputs("lr_still_drain", 0, 0, 4'b0100);
    tick(1);
    check_outputs("lr_idle", 0, 0, 4'b0001);
    tick(3);

    // Btn_R code held 50 cycles without ack while Btn_U is held
    exp_q.push_back(2);
    Btn_R = 1'b1;
    tick(10);
    Btn_R = 1'b0;
    tick(8);
    check_outputs("r_valid", 1, 2, 4'b1000);
    Btn_U = 1'b1;
    tick(50);
    check_outputs("r_hold", 1, 2, 4'b1000);
    code_ack = 1'b1;
    tick(1);
    code_ack = 1'b0;
    check_outputs("r_ack_drain", 0, 0, 4'b0100);
    check_value("r_ack_no_err", int'(multi_err), 0);
    tick(20);
    check_outputs("u_drain_hold", 0, 0, 4'b0100);
    Btn_U = 1'b0;
    tick(8);
    check_outputs("u_released", 0, 0, 4'b0001);
    code_ack = 1'b1;
    tick(2);
    code_ack = 1'b0;
    check_outputs("ack_in_idle", 0, 0, 4'b0001);

    // ON dropped while GREEN is presented
    exp_q.push_back(4);
    Btn_L = 1'b1;
    tick(10);
    Btn_L = 1'b0;
    tick(8);
    check_outputs("l_valid", 1, 4, 4'b1000);
    ON = 1'b0;
    tick(1);
    check_outputs("on_off", 0, 0, 4'b0001);
    ON = 1'b1;
    tick(2);

    // Asynchronous reset during HELD, then the still-held button re-debounces
    Btn_U = 1'b1;
    tick(8);
    check_outputs("u_held", 0, 0, 4'b0010);
    #1 Reset = 1'b1;
    #1;
    check_outputs("async_reset", 0, 0, 4'b0001);
    check_value("async_reset_err", int'(multi_err), 0);
    tick(2);
    Reset = 1'b0;
    tick(2 + DB);
    check_outputs("rereb_pre", 0, 0, 4'b0001);
    tick(1);
    check_outputs("rereb_held", 0, 0, 4'b0010);
    exp_q.push_back(1);
    Btn_U = 1'b0;
    tick(8);
    check_outputs("u_valid", 1, 1, 4'b1000);
    code_ack = 1'b1;
    tick(1);
    code_ack = 1'b0;
    check_outputs("u_acked", 0, 0, 4'b0001);
    tick(4);

    check_value("events_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
